iwm_controller: RTL and testbench



---
 rtl/iwm_controller.sv | 189 ++++++++++++++++++
 tb/tb_iwm_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/iwm_controller.sv
// IWM softswitch controller: turns $C0E0-$C0EF accesses into drive control lines,
// returns data/status/handshake bytes, and times motor-off delay and write-byte handshake.
module iwm_controller #(
  parameter int MOTOR_OFF_DELAY = 14318180
) (
  input  logic       CLK_14M,
  input  logic       RESET,
  input  logic       Q3,
  input  logic [3:0] ADDR,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  input  logic [7:0] DISK_DATA,
  input  logic       DISK_READY,
  output logic [3:0] MOTOR_PHASE,
  output logic       DISK_ACTIVE,
  output logic       DRIVE_SEL,
  output logic       WRITE_MODE,
  output logic       READ_DISK,
  output logic       WRITE_REG,
  output logic [7:0] WR_DATA,
  output logic       FAST_MODE
);
  localparam int CW = (MOTOR_OFF_DELAY > 2) ? $clog2(MOTOR_OFF_DELAY) : 1;
  localparam logic [CW-1:0] OFF_LOAD = CW'(MOTOR_OFF_DELAY - 1);

  logic [3:0]    phase_q, phase_d;
  logic          active_q, active_d;
  logic          sel_q, sel_d;
  logic          q6_q, q6_d;
  logic          q7_q, q7_d;
  logic [4:0]    mode_q, mode_d;
  logic [CW-1:0] off_cnt_q, off_cnt_d;
  logic          off_busy_q, off_busy_d;
  logic [7:0]    dout_q, dout_d;
  logic          rd_pulse_q, rd_pulse_d;
  logic          wr_pulse_q, wr_pulse_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          wr_empty_q, wr_empty_d;
  logic          no_underrun_q, no_underrun_d;
  logic          q3_q;
  logic [5:0]    byte_cnt_q, byte_cnt_d;

  logic       access, is_rd, is_wr, q3_rise;
  logic [5:0] byte_last;

  assign access    = RD | WR;
  assign is_wr     = WR;
  assign is_rd     = RD & ~WR;
  assign q3_rise   = Q3 & ~q3_q;
  assign byte_last = mode_q[3] ? 6'd31 : 6'd63;

  always_comb begin
    phase_d       = phase_q;
    active_d      = active_q;
    sel_d         = sel_q;
    q6_d          = q6_q;
    q7_d          = q7_q;
    mode_d        = mode_q;
    off_cnt_d     = off_cnt_q;
    off_busy_d    = off_busy_q;
    dout_d        = dout_q;
    rd_pulse_d    = 1'b0;
    wr_pulse_d    = 1'b0;
    wr_data_d     = wr_data_q;
    wr_empty_d    = wr_empty_q;
    no_underrun_d = no_underrun_q;
    byte_cnt_d    = byte_cnt_q;

    if (off_busy_q) begin
      if (off_cnt_q == '0) begin
        active_d   = 1'b0;
        off_busy_d = 1'b0;
      end else begin
        off_cnt_d = off_cnt_q - CW'(1);
      end
    end

    if (access) begin
      case (ADDR[3:1])
        3'd4: begin
          if (ADDR[0]) begin
            active_d   = 1'b1;
            off_busy_d = 1'b0;
          end else if (mode_q[2]) begin
            active_d   = 1'b0;
            off_busy_d = 1'b0;
          end else if (!off_busy_q) begin
            // a second motor-off while counting must not stretch the delay
            off_busy_d = 1'b1;
            off_cnt_d  = OFF_LOAD;
          end
        end
        3'd5:    sel_d = ADDR[0];
        3'd6:    q6_d  = ADDR[0];
        3'd7:    q7_d  = ADDR[0];
        default: phase_d[ADDR[2:1]] = ADDR[0];
      endcase
    end

    if (is_rd) begin
      case ({q7_d, q6_d})
        2'b00: begin
          dout_d     = active_d ? DISK_DATA : 8'hFF;
          rd_pulse_d = 1'b1;
        end
        2'b01:   dout_d = {~DISK_READY, 1'b0, active_d, mode_q};
        2'b10:   dout_d = {wr_empty_q, no_underrun_q, 6'b111111};
        default: dout_d = 8'hFF;
      endcase
    end

    if (active_q && q7_q && q3_rise) begin
      if (byte_cnt_q >= byte_last) begin
        byte_cnt_d = '0;
        if (!wr_empty_q) wr_empty_d    = 1'b1;
        else             no_underrun_d = 1'b0;
      end else begin
        byte_cnt_d = byte_cnt_q + 6'd1;
      end
    end

    // a write in the same cycle as an expiry refills the buffer, so it wins
    if (is_wr && q7_d && q6_d && ADDR[0]) begin
      if (active_d) begin
        wr_data_d  = DIN;
        wr_pulse_d = 1'b1;
        wr_empty_d = 1'b0;
      end else begin
        mode_d = DIN[4:0];
      end
    end

    if ((q7_q && !q7_d) || (active_q && !active_d)) begin
      byte_cnt_d    = '0;
      wr_empty_d    = 1'b1;
      no_underrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      phase_q       <= '0;
      active_q      <= 1'b0;
      sel_q         <= 1'b0;
      q6_q          <= 1'b0;
      q7_q          <= 1'b0;
      mode_q        <= '0;
      off_cnt_q     <= '0;
      off_busy_q    <= 1'b0;
      dout_q        <= '0;
      rd_pulse_q    <= 1'b0;
      wr_pulse_q    <= 1'b0;
      wr_data_q     <= '0;
      wr_empty_q    <= 1'b1;
      no_underrun_q <= 1'b1;
      q3_q          <= 1'b0;
      byte_cnt_q    <= '0;
    end else begin
      phase_q       <= phase_d;
      active_q      <= active_d;
      sel_q         <= sel_d;
      q6_q          <= q6_d;
      q7_q          <= q7_d;
      mode_q        <= mode_d;
      off_cnt_q     <= off_cnt_d;
      off_busy_q    <= off_busy_d;
      dout_q        <= dout_d;
      rd_pulse_q    <= rd_pulse_d;
      wr_pulse_q    <= wr_pulse_d;
      wr_data_q     <= wr_data_d;
      wr_empty_q    <= wr_empty_d;
      no_underrun_q <= no_underrun_d;
      q3_q          <= Q3;
      byte_cnt_q    <= byte_cnt_d;
    end
  end

  assign DOUT        = dout_q;
  assign MOTOR_PHASE = phase_q;
  assign DISK_ACTIVE = active_q;
  assign DRIVE_SEL   = sel_q;
  assign WRITE_MODE  = q7_q;
  assign READ_DISK   = rd_pulse_q;
  assign WRITE_REG   = wr_pulse_q;
  assign WR_DATA     = wr_data_q;
  assign FAST_MODE   = mode_q[3];
endmodule

// File: tb/tb_iwm_controller.sv
// Directed bench for iwm_controller: vector table for softswitch decode plus
// hand sequences for motor-off timing, mode write, write handshake and strobe corners.
module tb_iwm_controller;
  localparam int DLY = 100;

  logic       CLK_14M, RESET, Q3, RD, WR, DISK_READY;
  logic [3:0] ADDR, MOTOR_PHASE;
  logic [7:0] DIN, DOUT, DISK_DATA, WR_DATA;
  logic       DISK_ACTIVE, DRIVE_SEL, WRITE_MODE, READ_DISK, WRITE_REG, FAST_MODE;

  int checks = 0;
  int errors = 0;

  iwm_controller #(.MOTOR_OFF_DELAY(DLY)) dut (
    .CLK_14M(CLK_14M), .RESET(RESET), .Q3(Q3), .ADDR(ADDR), .RD(RD), .WR(WR),
    .DIN(DIN), .DOUT(DOUT), .DISK_DATA(DISK_DATA), .DISK_READY(DISK_READY),
    .MOTOR_PHASE(MOTOR_PHASE), .DISK_ACTIVE(DISK_ACTIVE), .DRIVE_SEL(DRIVE_SEL),
    .WRITE_MODE(WRITE_MODE), .READ_DISK(READ_DISK), .WRITE_REG(WRITE_REG),
    .WR_DATA(WR_DATA), .FAST_MODE(FAST_MODE)
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  typedef struct {
    logic       rd, wr;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic [3:0] e_phase;
    logic       e_act, e_sel, e_wm, e_rdp, e_wrp;
    logic [7:0] e_wrdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_14M);
    #1;
  endtask

  task automatic acc(input logic rd, input logic wr, input logic [3:0] a, input logic [7:0] d);
    RD = rd; WR = wr; ADDR = a; DIN = d;
    tick();
    RD = 1'b0; WR = 1'b0;
  endtask

  task automatic q3_edges(input int n);
    for (int k = 0; k < n; k++) begin
      Q3 = 1'b1; tick(); tick();
      Q3 = 1'b0; tick(); tick();
    end
  endtask

  // Called at the sample point of cycle 'from' after a motor-off strobe;
  // DISK_ACTIVE must hold through cycle DLY and be low at DLY+1.
  task automatic wait_fall(input string name, input int from);
    int bad_at;
    bad_at = -1;
    for (int c = from; c <= DLY; c++) begin
      if (DISK_ACTIVE !== 1'b1 && bad_at < 0) bad_at = c;
      tick();
    end
    checks++;
    if (bad_at >= 0) begin
      errors++;
      $display("FAIL %s hold: DISK_ACTIVE dropped at cycle %0d, required high through %0d", name, bad_at, DLY);
    end
    chk({name, " fall"}, 8'(DISK_ACTIVE), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    RESET = 1'b1; Q3 = 1'b0; RD = 1'b0; WR = 1'b0; ADDR = 4'h0; DIN = 8'h00;
    DISK_DATA = 8'hD5; DISK_READY = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    tick();

    chk("rst dout", DOUT, 8'h00);
    chk("rst phase", 8'(MOTOR_PHASE), 8'h00);
    chk("rst ctl", 8'({DISK_ACTIVE, DRIVE_SEL, WRITE_MODE, READ_DISK, WRITE_REG, FAST_MODE}), 8'h00);
    chk("rst wrdata", WR_DATA, 8'h00);

    //                rd    wr    addr   din    dout   phase    act   sel   wm    rdp   wrp   wrdata
    tbl.push_back('{1'b1, 1'b0, 4'hD, 8'h00, 8'h80, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 4'hC, 8'h00, 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 4'h1, 8'h00, 8'hFF, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 4'h3, 8'h00, 8'hFF, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 4'h9, 8'h00, 8'hD5, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 8'h00, 8'hD5, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 4'hB, 8'h00, 8'hD5, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 4'hA, 8'h00, 8'hD5, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 8'h0C, 8'hD5, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 4'hD, 8'hA5, 8'hD5, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5});
    tbl.push_back('{1'b1, 1'b0, 4'hC, 8'h00, 8'h7F, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5});
    tbl.push_back('{1'b1, 1'b0, 4'hE, 8'h00, 8'hD5, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5});

    foreach (tbl[i]) begin
      acc(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
      chk($sformatf("v%0d dout", i), DOUT, tbl[i].e_dout);
      chk($sformatf("v%0d phase", i), 8'(MOTOR_PHASE), 8'(tbl[i].e_phase));
      chk($sformatf("v%0d ctl", i),
          8'({DISK_ACTIVE, DRIVE_SEL, WRITE_MODE, READ_DISK, WRITE_REG}),
          8'({tbl[i].e_act, tbl[i].e_sel, tbl[i].e_wm, tbl[i].e_rdp, tbl[i].e_wrp}));
      chk($sformatf("v%0d wrdata", i), WR_DATA, tbl[i].e_wrdata);
    end

    // motor-off delay, mode[2]=0
    acc(1'b1, 1'b0, 4'h8, 8'h00);
    wait_fall("off delay", 1);

    // motor-on at cycle 50 cancels the countdown
    acc(1'b1, 1'b0, 4'h9, 8'h00);
    acc(1'b1, 1'b0, 4'h8, 8'h00);
    repeat (48) tick();
    acc(1'b1, 1'b0, 4'h9, 8'h00);
    bad = 0;
    for (int c = 0; c < 150; c++) begin
      if (DISK_ACTIVE !== 1'b1) bad = 1;
      tick();
    end
    chk("cancel stays on", 8'(bad), 8'h00);

    // repeated motor-off mid-count keeps the original deadline
    acc(1'b1, 1'b0, 4'h8, 8'h00);
    repeat (48) tick();
    acc(1'b1, 1'b0, 4'h8, 8'h00);
    wait_fall("repeat off", 50);

    // mode write with motor off, then status and data-latch reads
    DISK_READY = 1'b1;
    acc(1'b1, 1'b0, 4'hD, 8'h00);
    chk("status idle", DOUT, 8'h00);
    acc(1'b0, 1'b1, 4'hF, 8'h0C);
    chk("fast mode", 8'(FAST_MODE), 8'h01);
    chk("mode not data", 8'(WRITE_REG), 8'h00);
    acc(1'b1, 1'b0, 4'hE, 8'h00);
    chk("status mode", DOUT, 8'h0C);
    acc(1'b1, 1'b0, 4'hC, 8'h00);
    chk("latch motor off", DOUT, 8'hFF);
    acc(1'b1, 1'b0, 4'h9, 8'h00);
    acc(1'b1, 1'b0, 4'hC, 8'h00);
    chk("latch data", DOUT, 8'hD5);
    chk("read pulse", 8'(READ_DISK), 8'h01);
    tick();
    chk("read pulse end", 8'(READ_DISK), 8'h00);
    chk("dout held", DOUT, 8'hD5);

    // mode[2]=1: immediate motor-off
    acc(1'b1, 1'b0, 4'h8, 8'h00);
    chk("fast off", 8'(DISK_ACTIVE), 8'h00);

    // write handshake, slow byte timer
    acc(1'b0, 1'b1, 4'hD, 8'h00);
    acc(1'b0, 1'b1, 4'hF, 8'h00);
    chk("slow mode", 8'(FAST_MODE), 8'h00);
    acc(1'b1, 1'b0, 4'h9, 8'h00);
    chk("reg11 read", DOUT, 8'hFF);
    acc(1'b0, 1'b1, 4'hF, 8'hFF);
    chk("wr pulse", 8'(WRITE_REG), 8'h01);
    chk("wr data", WR_DATA, 8'hFF);
    acc(1'b1, 1'b0, 4'hC, 8'h00);
    chk("hs full", DOUT, 8'h7F);
    q3_edges(63);
    acc(1'b1, 1'b0, 4'hC, 8'h00);
    chk("hs 63 edges", DOUT, 8'h7F);
    q3_edges(1);
    acc(1'b1, 1'b0, 4'hC, 8'h00);
    chk("hs 64 edges", DOUT, 8'hFF);
    q3_edges(63);
    acc(1'b1, 1'b0, 4'hC, 8'h00);
    chk("hs 127 edges", DOUT, 8'hFF);
    q3_edges(1);
    acc(1'b1, 1'b0, 4'hC, 8'h00);
    chk("hs underrun", DOUT, 8'hBF);
    acc(1'b1, 1'b0, 4'hE, 8'h00);
    chk("leave write", 8'(WRITE_MODE), 8'h00);
    acc(1'b1, 1'b0, 4'hF, 8'h00);
    chk("hs restored", DOUT, 8'hFF);

    // RD and WR together behave as a write: no latch read
    acc(1'b1, 1'b0, 4'hE, 8'h00);
    chk("latch before", DOUT, 8'hD5);
    DISK_DATA = 8'h3C;
    acc(1'b1, 1'b1, 4'hC, 8'h00);
    chk("both no pulse", 8'(READ_DISK), 8'h00);
    chk("both dout", DOUT, 8'hD5);

    // reset mid-countdown drops DISK_ACTIVE without a clock edge
    acc(1'b1, 1'b0, 4'h8, 8'h00);
    repeat (10) tick();
    chk("pre-reset active", 8'(DISK_ACTIVE), 8'h01);
    RESET = 1'b1;
    #1;
    chk("async reset active", 8'(DISK_ACTIVE), 8'h00);
    chk("async reset dout", DOUT, 8'h00);
    tick();
    RESET = 1'b0;
    tick();
    chk("post reset wrdata", WR_DATA, 8'h00);
    chk("post reset phase", 8'(MOTOR_PHASE), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
